// File: rtl/mux4x1_arbiter_if.sv
// Requester/mux/output-slot bundle for the round-robin 4-to-1 mux scheduler.
// The master side drives requests, the mux output and downstream ready.
interface mux4x1_arbiter_if #(
    parameter int unsigned WIDTH = 2
);
    logic [3:0]       req;
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output req, mux_y, out_ready,
        input  ack, sel, out_data, out_src, out_valid
    );

    modport slave (
        input  req, mux_y, out_ready,
        output ack, sel, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux4x1_arbiter.sv
// Round-robin scheduler that shares an external 4-to-1 mux among four requesters.
// It captures the selected leg into a valid/ready output slot.
module mux4x1_arbiter #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned BURST_MAX = 4
) (
    input logic                 clk,
    input logic                 rst,
    mux4x1_arbiter_if.slave     bus
);
    localparam int unsigned          CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(BURST_MAX);

    logic [1:0]       r_last_grant;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_src;

    logic       w_slot_free;
    logic       w_others;
    logic       w_skip_last;
    logic       w_found;
    logic       w_grant;
    logic [1:0] w_winner;
    logic [1:0] w_idx;

    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Scan last_grant+1 .. last_grant+4; the previous winner is skipped once its burst is spent
    always_comb begin
        w_others    = |(bus.req & ~(4'b0001 << r_last_grant));
        w_skip_last = (r_burst_cnt == CNT_MAX) && w_others;
        w_found     = 1'b0;
        w_winner    = r_last_grant;
        w_idx       = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && bus.req[w_idx] &&
                !((w_idx == r_last_grant) && w_skip_last)) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        w_grant = !rst && w_slot_free && w_found;
    end

    // Select holds on the last winner when idle so the mux does not toggle
    assign bus.sel       = rst ? 2'd3 : (w_grant ? w_winner : r_last_grant);
    assign bus.ack       = w_grant ? (4'b0001 << w_winner) : 4'b0000;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= 2'd0;
            r_last_grant <= 2'd3;
            r_burst_cnt  <= '0;
        end else if (w_grant) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= bus.mux_y;
            r_out_src    <= w_winner;
            r_last_grant <= w_winner;
            if (w_winner == r_last_grant) begin
                r_burst_cnt <= (r_burst_cnt == CNT_MAX) ? CNT_MAX
                                                        : r_burst_cnt + CNT_W'(1);
            end else begin
                r_burst_cnt <= CNT_W'(1);
            end
        end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Directed bench for mux4x1_arbiter: external mux modelled from the select,
// expected values hand-computed per step.
module tb_mux4x1_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [1:0] legs [4];

    mux4x1_arbiter_if #(.WIDTH(2)) bus ();

    mux4x1_arbiter #(.WIDTH(2), .BURST_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mux_y = legs[bus.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        legs[0] = 2'b10;
        legs[1] = 2'b11;
        legs[2] = 2'b01;
        legs[3] = 2'b00;
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_src",   32'(bus.out_src),   32'd0);
        chk("rst_ack",   32'(bus.ack),       32'd0);
        chk("rst_sel",   32'(bus.sel),       32'd3);

        // 1: single request from requester 0
        rst = 1'b0;
        bus.req = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_sel", 32'(bus.sel), 32'd0);
        chk("t1_ack", 32'(bus.ack), 32'b0001);
        tick();
        bus.req = 4'b0000;
        #1;
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data",  32'(bus.out_data),  32'b10);
        chk("t1_src",   32'(bus.out_src),   32'd0);
        chk("t1_idle_ack", 32'(bus.ack),    32'd0);
        chk("t1_idle_sel", 32'(bus.sel),    32'd0);
        tick();
        chk("t1_drain", 32'(bus.out_valid), 32'd0);

        // 2: all four requesting, round robin from 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_sel", 32'(bus.sel), 32'(i % 4));
            chk("t2_ack", 32'(bus.ack), 32'(1 << (i % 4)));
            tick();
            chk("t2_src",   32'(bus.out_src),   32'(i % 4));
            chk("t2_data",  32'(bus.out_data),  32'(legs[i % 4]));
            chk("t2_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.req = 4'b0000;
        tick();

        // 3: requester 2 alone streams every cycle
        bus.req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_ack", 32'(bus.ack), 32'b0100);
            chk("t3_sel", 32'(bus.sel), 32'd2);
            tick();
            chk("t3_data", 32'(bus.out_data), 32'b01);
            chk("t3_src",  32'(bus.out_src),  32'd2);
        end
        chk("t3_burst_sat", 32'(dut.r_burst_cnt), 32'd4);

        // 4: back-pressure holds slot and blocks grants
        bus.req = 4'b0010;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_ack",   32'(bus.ack),       32'd0);
            chk("t4_hold_data",  32'(bus.out_data),  32'b01);
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_ack", 32'(bus.ack), 32'b0010);
        chk("t4_sel", 32'(bus.sel), 32'd1);
        tick();
        chk("t4_data",  32'(bus.out_data),  32'b11);
        chk("t4_src",   32'(bus.out_src),   32'd1);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);

        // 5: requester 3 then 0 and 3 competing
        bus.req = 4'b1000;
        #1;
        chk("t5_ack3", 32'(bus.ack), 32'b1000);
        tick();
        chk("t5_src3", 32'(bus.out_src), 32'd3);
        bus.req = 4'b1001;
        #1;
        chk("t5_ack0", 32'(bus.ack), 32'b0001);
        chk("t5_sel0", 32'(bus.sel), 32'd0);
        tick();
        chk("t5_src0",  32'(bus.out_src),  32'd0);
        chk("t5_data0", 32'(bus.out_data), 32'b10);
        #1;
        chk("t5_ack3b", 32'(bus.ack), 32'b1000);
        tick();
        chk("t5_src3b", 32'(bus.out_src), 32'd3);

        // 6: reset mid-transfer discards the slot and restarts at requester 0
        bus.req = 4'b1111;
        rst = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(bus.ack), 32'd0);
        chk("t6_rst_sel", 32'(bus.sel), 32'd3);
        tick();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_ack",   32'(bus.ack),       32'd0);
        chk("t6_sel",   32'(bus.sel),       32'd3);
        rst = 1'b0;
        #1;
        chk("t6_first_ack", 32'(bus.ack), 32'b0001);
        tick();
        chk("t6_first_src", 32'(bus.out_src), 32'd0);
        bus.req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
